// File: rtl/line_clear_ctrl.sv
// Lock/line-clear sequencer: locks the landed piece, scans bottom-up for full rows,
// shifts each one out, then tallies lines and releases the next spawn. Optional score via LINE_CLEAR_SCORE_EN.
module line_clear_ctrl #(
   parameter int ROWS    = 20,
   parameter int TOTAL_W = 10
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  lock_req,
   input  logic [3:0][4:0]       blocks_ypos,
   input  logic [ROWS-1:0]       row_full,
   output logic                  lock_en,
   output logic                  lock_ack,
   output logic                  shift_en,
   output logic [4:0]            shift_row,
   output logic                  busy,
   output logic                  spawn_req,
   output logic [2:0]            lines_cleared,
   output logic [TOTAL_W-1:0]    total_lines,
   output logic                  game_over
`ifdef LINE_CLEAR_SCORE_EN
   ,
   output logic [19:0]           score
`endif
);

   typedef enum logic [2:0] {IDLE, LOCK, SETTLE, SCAN, SHIFT, DONE} state_t;

   state_t               state_reg, state_next;
   logic [4:0]           ptr_reg, ptr_next;
   logic [2:0]           clr_cnt_reg;
   logic                 topout_reg;
   logic [2:0]           lines_cleared_reg;
   logic [TOTAL_W-1:0]   total_reg;
   logic                 game_over_reg;
   logic [3:0]           low_row;
   logic [TOTAL_W:0]     total_sum;
   logic                 topped_out;

   // A cell in row 0 or 1 at lock time means the stack reached the spawn area.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_low
         assign low_row[gi] = (blocks_ypos[gi][4:1] == 4'd0);
      end
   endgenerate

   assign total_sum  = {1'b0, total_reg} + (TOTAL_W+1)'(clr_cnt_reg);
   assign topped_out = topout_reg && (clr_cnt_reg == 3'd0);

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE:   if (lock_req && !game_over_reg) state_next = LOCK;
         LOCK: begin
            state_next = SETTLE;
            ptr_next   = 5'(ROWS - 1);
         end
         SETTLE: state_next = SCAN;
         SCAN: begin
            if (row_full[ptr_reg])      state_next = SHIFT;
            else if (ptr_reg == 5'd0)   state_next = DONE;
            else                        ptr_next   = ptr_reg - 5'd1;
         end
         SHIFT:  state_next = SETTLE;
         DONE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef LINE_CLEAR_SCORE_EN
   logic [19:0] score_reg;
   logic [19:0] score_add;
   logic [20:0] score_sum;

   always_comb begin
      score_add = 20'd0;
      case (clr_cnt_reg)
         3'd1:    score_add = 20'd40;
         3'd2:    score_add = 20'd100;
         3'd3:    score_add = 20'd300;
         3'd4:    score_add = 20'd1200;
         default: score_add = 20'd0;
      endcase
   end

   assign score_sum = {1'b0, score_reg} + {1'b0, score_add};

   always_ff @(posedge Clk) begin
      if (!Reset_n)                score_reg <= 20'd0;
      else if (state_reg == DONE)  score_reg <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
   end

   assign score = score_reg;
`endif

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_reg         <= IDLE;
         ptr_reg           <= 5'(ROWS - 1);
         clr_cnt_reg       <= 3'd0;
         topout_reg        <= 1'b0;
         lines_cleared_reg <= 3'd0;
         total_reg         <= '0;
         game_over_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         if (state_reg == IDLE && state_next == LOCK) begin
            topout_reg  <= |low_row;
            clr_cnt_reg <= 3'd0;
         end
         if (state_reg == SHIFT && clr_cnt_reg != 3'd4)
            clr_cnt_reg <= clr_cnt_reg + 3'd1;
         if (state_reg == DONE) begin
            lines_cleared_reg <= clr_cnt_reg;
            total_reg         <= total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
            if (topped_out) game_over_reg <= 1'b1;
         end
      end
   end

   assign lock_en       = (state_reg == LOCK);
   assign lock_ack      = lock_en;
   assign shift_en      = (state_reg == SHIFT);
   assign shift_row     = shift_en ? ptr_reg : 5'd0;
   assign busy          = (state_reg != IDLE);
   assign spawn_req     = (state_reg == DONE) && !topped_out;
   assign lines_cleared = lines_cleared_reg;
   assign total_lines   = total_reg;
   assign game_over     = game_over_reg;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a tiny playfield model reacting to shift_en.
module tb_line_clear_ctrl;

   localparam int TW = 4;

   logic            Clk = 1'b0;
   logic            Reset_n;
   logic            lock_req;
   logic [3:0][4:0] blocks_ypos;
   logic [19:0]     row_full;
   logic            lock_en, lock_ack, shift_en, busy, spawn_req, game_over;
   logic [4:0]      shift_row;
   logic [2:0]      lines_cleared;
   logic [TW-1:0]   total_lines;
`ifdef LINE_CLEAR_SCORE_EN
   logic [19:0]     score;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   logic        load_req = 1'b0;
   logic [19:0] load_val = '0;

   line_clear_ctrl #(.ROWS(20), .TOTAL_W(TW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .lock_req(lock_req), .blocks_ypos(blocks_ypos),
      .row_full(row_full), .lock_en(lock_en), .lock_ack(lock_ack), .shift_en(shift_en),
      .shift_row(shift_row), .busy(busy), .spawn_req(spawn_req),
      .lines_cleared(lines_cleared), .total_lines(total_lines), .game_over(game_over)
`ifdef LINE_CLEAR_SCORE_EN
      , .score(score)
`endif
   );

   always #5 Clk = ~Clk;

   // Playfield model: rows 0..shift_row-1 move down one, row 0 empties.
   always @(posedge Clk) begin
      if (load_req) row_full <= load_val;
      else if (shift_en) begin
         for (int i = 19; i >= 1; i--)
            if (i <= int'(shift_row)) row_full[i] <= row_full[i-1];
         row_full[0] <= 1'b0;
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic load_field(input logic [19:0] v);
      load_val = v;
      load_req = 1'b1;
      step();
      load_req = 1'b0;
   endtask

   // Runs one lock transaction; cycle 1 is the cycle after the sampling edge.
   task automatic do_lock(input logic [19:0] ypos, input int hold,
                          output int lock_at, output int spawn_at, output int nshift,
                          output int nack, output int nbad19);
      int c;
      blocks_ypos = ypos;
      lock_req = 1'b1;
      step();
      c = 1; lock_at = -1; spawn_at = -1; nshift = 0; nack = 0; nbad19 = 0;
      while (c < 200) begin
         if (lock_en && lock_at < 0) lock_at = c;
         if (lock_ack) nack++;
         if (shift_en) begin
            nshift++;
            if (shift_row != 5'd19) nbad19++;
         end
         if (spawn_req) spawn_at = c;
         if (!busy) break;
         lock_req = (c < hold);
         step();
         c++;
      end
      lock_req = 1'b0;
      if (c >= 200) chk("lock_timeout", 32'(c), 32'd0);
   endtask

   initial begin
      int la, sa, ns, na, nb, c, bad;
      logic [19:0] normal;
      normal = {5'd12, 5'd11, 5'd10, 5'd10};
      Reset_n = 1'b0; lock_req = 1'b0; blocks_ypos = normal;
      load_field(20'd0);
      step();
      chk("reset_outs", {lock_en, lock_ack, shift_en, spawn_req, busy, game_over,
                         lines_cleared, total_lines, shift_row}, 32'd0);
      Reset_n = 1'b1;
      step();

      // No full rows
      do_lock(normal, 1, la, sa, ns, na, nb);
      chk("t1_lock_at", 32'(la), 32'd1);
      chk("t1_spawn_at", 32'(sa), 32'd23);
      chk("t1_nshift", 32'(ns), 32'd0);
      chk("t1_lines", 32'(lines_cleared), 32'd0);
      chk("t1_total", 32'(total_lines), 32'd0);

      // Bottom row full
      load_field(20'h80000);
      do_lock(normal, 1, la, sa, ns, na, nb);
      chk("t2_spawn_at", 32'(sa), 32'd26);
      chk("t2_nshift", 32'(ns), 32'd1);
      chk("t2_row19", 32'(nb), 32'd0);
      chk("t2_lines", 32'(lines_cleared), 32'd1);
      chk("t2_total", 32'(total_lines), 32'd1);
`ifdef LINE_CLEAR_SCORE_EN
      chk("t2_score", 32'(score), 32'd40);
`endif

      // Tetris, rows 16..19
      load_field(20'hF0000);
      do_lock(normal, 1, la, sa, ns, na, nb);
      chk("t3_spawn_at", 32'(sa), 32'd35);
      chk("t3_nshift", 32'(ns), 32'd4);
      chk("t3_row19", 32'(nb), 32'd0);
      chk("t3_lines", 32'(lines_cleared), 32'd4);
      chk("t3_total", 32'(total_lines), 32'd5);
      chk("t3_field", 32'(row_full), 32'd0);
`ifdef LINE_CLEAR_SCORE_EN
      chk("t3_score", 32'(score), 32'd1240);
`endif

      // lock_req held through SCAN
      do_lock(normal, 20, la, sa, ns, na, nb);
      chk("t4_nack", 32'(na), 32'd1);
      chk("t4_spawn_at", 32'(sa), 32'd23);
      step();
      chk("t4_idle", 32'(busy), 32'd0);

      // Drive total_lines into saturation
      load_field(20'hF0000);
      do_lock(normal, 1, la, sa, ns, na, nb);
      load_field(20'hF0000);
      do_lock(normal, 1, la, sa, ns, na, nb);
      chk("t5_total13", 32'(total_lines), 32'd13);
      load_field(20'hF0000);
      do_lock(normal, 1, la, sa, ns, na, nb);
      chk("t5_total_sat", 32'(total_lines), 32'd15);
      load_field(20'h80000);
      do_lock(normal, 1, la, sa, ns, na, nb);
      chk("t5_total_hold", 32'(total_lines), 32'd15);
      chk("t5_lines", 32'(lines_cleared), 32'd1);
`ifdef LINE_CLEAR_SCORE_EN
      chk("t5_score", 32'(score), 32'd4880);
`endif

      // Reset during SHIFT
      load_field(20'h80000);
      blocks_ypos = normal;
      lock_req = 1'b1;
      step();
      lock_req = 1'b0;
      c = 0;
      while (!shift_en && c < 50) begin step(); c++; end
      chk("t6_reach_shift", 32'(shift_en), 32'd1);
      Reset_n = 1'b0;
      step();
      chk("t6_reset_outs", {lock_en, lock_ack, shift_en, spawn_req, busy, game_over,
                            lines_cleared, total_lines, shift_row}, 32'd0);
      Reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (shift_en || spawn_req || busy) bad++;
      end
      chk("t6_quiet", 32'(bad), 32'd0);

      // Top-out: cell at row 1, nothing cleared
      load_field(20'd0);
      do_lock({5'd3, 5'd2, 5'd2, 5'd1}, 1, la, sa, ns, na, nb);
      chk("t7_no_spawn", 32'(sa), 32'hFFFFFFFF);
      chk("t7_game_over", 32'(game_over), 32'd1);
      chk("t7_lines", 32'(lines_cleared), 32'd0);
      do_lock(normal, 1, la, sa, ns, na, nb);
      chk("t7_ignored_ack", 32'(na), 32'd0);
      chk("t7_ignored_busy", 32'(busy), 32'd0);
      Reset_n = 1'b0;
      step();
      chk("t7_go_cleared", 32'(game_over), 32'd0);
      Reset_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/line_clear_ctrl.md
LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 20, meaning playfield height in rows (row 0 = top).
REQ-002 SHALL have parameter TOTAL_W, default 10, meaning width of the running line counter.
REQ-003 SHALL have port Clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1, meaning a synchronous, active-low reset.
REQ-005 SHALL have port lock_req, input, 1, meaning the falling piece has landed and must be locked.
REQ-006 SHALL have port blocks_ypos[3:0], input, 4x5, meaning the row of each of the piece's four cells, sampled with lock_req.
REQ-007 SHALL have port row_full[ROWS-1:0], input, ROWS, meaning the field datapath reports that all 10 cells of each row are set.
REQ-008 SHALL have port lock_en, output, 1, meaning a one-cycle command to the field to write the piece cells.
REQ-009 SHALL have port lock_ack, output, 1, meaning lock_req was accepted; equal to lock_en.
REQ-010 SHALL have port shift_en, output, 1, meaning a one-cycle command to the field to copy rows 0..shift_row-1 down by one and clear row 0.
REQ-011 SHALL have port shift_row, output, 5, meaning the row being removed; valid only while shift_en=1.
REQ-012 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-013 SHALL have port spawn_req, output, 1, meaning a one-cycle pulse that the next piece may spawn.
REQ-014 SHALL have port lines_cleared, output, 3, meaning rows removed by the last lock (0-4), registered.
REQ-015 SHALL have port total_lines, output, TOTAL_W, meaning the running count of rows removed, saturating at all-ones.
REQ-016 SHALL have port game_over, output, 1, meaning a top-out occurred; sticky until reset.

Function
REQ-017 SHALL implement a Moore FSM with states IDLE, LOCK, SETTLE, SCAN, SHIFT and DONE; all outputs SHALL be registered or decoded from state only.
REQ-018 SHALL leave IDLE for LOCK at the edge where lock_req=1 and game_over=0, capturing blocks_ypos and a top-out flag set if any ypos is 0 or 1.
REQ-019 SHALL assert lock_en and lock_ack for exactly the LOCK cycle, then go to SETTLE.
REQ-020 SHALL use SETTLE as one cycle to let row_full reflect the write, then enter SCAN with pointer = ROWS-1 after LOCK, or with the pointer unchanged after SHIFT.
REQ-021 SHALL, in SCAN, go to SHIFT if row_full[ptr]=1; otherwise go to DONE if ptr=0, else decrement ptr.
REQ-022 SHALL, in SHIFT, assert shift_en with shift_row=ptr for one cycle, increment the clear counter (3 bits, saturating at 4), and go to SETTLE; the same row SHALL be rescanned.
REQ-023 SHALL, in DONE, load lines_cleared, add it to total_lines with saturation, and go to IDLE. If the top-out flag is set and the clear count is 0, it SHALL set game_over and withhold spawn_req; otherwise it SHALL pulse spawn_req.
REQ-024 SHALL meet this latency: spawn_req asserts 23+3k cycles after the lock_req sampling edge, where k is the number of rows cleared.
REQ-025 SHALL ignore lock_req while busy=1 or game_over=1, with no ack and no queueing.
REQ-026 SHALL handle row 0 full by shifting with shift_row=0, which only clears row 0.

Reset
REQ-027 SHALL, with Reset_n=0 at a clock edge, put the FSM in IDLE, set ptr=ROWS-1, and drive lock_en, lock_ack, shift_en, spawn_req, busy, game_over, lines_cleared and total_lines to 0 and shift_row to 0.
REQ-028 SHALL, on reset mid-sequence, abort without issuing any further shift_en or spawn_req.

Configuration
REQ-029 SHALL provide macro LINE_CLEAR_SCORE_EN. When it is defined, a 20-bit output score SHALL add 40, 100, 300 or 1200 at DONE for 1, 2, 3 or 4 lines, saturate at 20'hFFFFF, and reset to 0. When it is undefined, the score port and its logic SHALL be absent.

Verification
REQ-030 SHALL cover: no full rows, lock_req at cycle 0 -> lock_en at cycle 1, spawn_req at cycle 23, lines_cleared=0.
REQ-031 SHALL cover: row 19 full and cleared after the shift -> one shift_en with shift_row=19, spawn_req at cycle 26, lines_cleared=1, total_lines=1.
REQ-032 SHALL cover: rows 16-19 full (tetris) -> four shift_en with shift_row=19 each, lines_cleared=4, score +1200 when LINE_CLEAR_SCORE_EN is defined.
REQ-033 SHALL cover: lock with ypos 1 and no clears -> game_over=1, no spawn_req, and a later lock_req ignored.
REQ-034 SHALL cover: lock_req held during SCAN -> no second lock_ack; Reset_n=0 during SHIFT -> all outputs 0 next cycle and busy=0.
REQ-035 SHALL cover: total_lines preloaded near saturation via repeated clears -> total_lines holds all-ones and does not wrap.
